wall_texv_stepper: RTL and testbench

- Per-line texture-coordinate generator directly upstream of the wall texture ROM.
- At each line start it latches the traced wall parameters: side, wall type id, texture column, wall height, texture step and texture start offset.
- It then walks the line one pixel per enable and classifies each pixel as ceiling, wall or floor.
- For wall pixels it presents side/wtid/col/row to the ROM; row is a fixed-point accumulator stepped per pixel.

---
 rtl/wall_texv_stepper_pkg.sv | 38 +++
 rtl/wall_texv_stepper_texv_accum.sv | 32 +++
 rtl/wall_texv_stepper.sv | 162 ++++++++++++++++
 tb/tb_wall_texv_stepper.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/wall_texv_stepper_pkg.sv
// Shared definitions for the wall texture-coordinate stepper: line geometry,
// the Q6.STEP_FRAC texture-row format, region and state encodings, ROM target widths.
package wall_texv_stepper_pkg;

    localparam int VIEW_WIDTH_DEF = 640;
    localparam int STEP_FRAC_DEF  = 10;
    localparam int CNT_BITS_DEF   = 10;

    // Texture ROM address fields
    localparam int TEX_ROW_BITS  = 6;
    localparam int TEX_COL_BITS  = 6;
    localparam int TEX_WTID_BITS = 2;
    localparam int TEXV_BITS_DEF = TEX_ROW_BITS + STEP_FRAC_DEF;

    typedef enum logic [1:0] {
        REGION_NONE  = 2'd0,
        REGION_CEIL  = 2'd1,
        REGION_WALL  = 2'd2,
        REGION_FLOOR = 2'd3
    } region_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CEIL  = 2'd1,
        ST_WALL  = 2'd2,
        ST_FLOOR = 2'd3
    } state_t;

    function automatic region_t state_region(input state_t st);
        case (st)
            ST_CEIL:  return REGION_CEIL;
            ST_WALL:  return REGION_WALL;
            ST_FLOOR: return REGION_FLOOR;
            default:  return REGION_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wall_texv_stepper_texv_accum.sv
// Fixed-point texture-row accumulator: loads the start offset, steps per wall
// pixel with natural wrap, and exposes the integer row field.
module texv_accum
    import wall_texv_stepper_pkg::*;
#(
    parameter int STEP_FRAC = STEP_FRAC_DEF
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            load,
    input  logic [TEX_ROW_BITS+STEP_FRAC-1:0] load_val,
    input  logic                            step_en,
    input  logic [TEX_ROW_BITS+STEP_FRAC-1:0] step,
    output logic [TEX_ROW_BITS-1:0]         row
);

    logic [TEX_ROW_BITS+STEP_FRAC-1:0] acc_reg;

    // Wrapping mod 2^(6+STEP_FRAC) makes rows repeat every 64.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (load) begin
            acc_reg <= load_val;
        end else if (step_en) begin
            acc_reg <= acc_reg + step;
        end
    end

    assign row = acc_reg[TEX_ROW_BITS+STEP_FRAC-1:STEP_FRAC];

endmodule

// File: rtl/wall_texv_stepper.sv
// Per-line texture-coordinate generator: classifies each pixel of a traced line
// as ceiling/wall/floor and presents side/wtid/col/row to the wall texture ROM.
module wall_texv_stepper
    import wall_texv_stepper_pkg::*;
#(
    parameter int VIEW_WIDTH = VIEW_WIDTH_DEF,
    parameter int STEP_FRAC  = STEP_FRAC_DEF,
    parameter int CNT_BITS   = CNT_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  line_start,
    input  logic                  pixel_en,
    input  logic                  in_side,
    input  logic [1:0]            in_wtid,
    input  logic [5:0]            in_col,
    input  logic [CNT_BITS-1:0]   wall_height,
    input  logic [6+STEP_FRAC-1:0] texv_step,
    input  logic [6+STEP_FRAC-1:0] texv_init,
    output logic                  tex_side,
    output logic [1:0]            tex_wtid,
    output logic [5:0]            tex_col,
    output logic [5:0]            tex_row,
    output logic                  wall_en,
    output logic [1:0]            region,
    output logic                  out_valid,
    output logic                  line_done
);

    localparam logic [CNT_BITS-1:0] VW = CNT_BITS'(VIEW_WIDTH);

    state_t                  state_reg, state_next;
    logic [CNT_BITS-1:0]     pix_reg, pix_next, pix_inc;
    logic [CNT_BITS-1:0]     wall_top_reg, wall_end_reg;
    logic                    has_wall_reg;
    logic [6+STEP_FRAC-1:0]  step_reg;
    logic                    side_reg;
    logic [1:0]              wtid_reg;
    logic [5:0]              col_reg;
    logic [5:0]              row_reg, row_next;
    logic                    wall_en_reg, wall_en_next;
    region_t                 region_reg, region_next;
    logic                    valid_reg, valid_next;
    logic                    done_reg, done_next;

    logic [CNT_BITS-1:0]     h_clamp, h_eff, wall_top, wall_end;
    logic                    acc_step;
    logic [5:0]              acc_row;

    // Wall span bounds for the incoming line; a missing wall leaves an even ceiling/floor split.
    always_comb begin
        h_clamp  = (wall_height > VW) ? VW : wall_height;
        h_eff    = (in_wtid == 2'd0) ? '0 : h_clamp;
        wall_top = (VW - h_eff) >> 1;
        wall_end = wall_top + h_eff;
    end

    assign pix_inc = pix_reg + CNT_BITS'(1);

    always_comb begin
        state_next   = state_reg;
        pix_next     = pix_reg;
        row_next     = row_reg;
        wall_en_next = wall_en_reg;
        region_next  = region_reg;
        valid_next   = 1'b0;
        done_next    = 1'b0;
        acc_step     = 1'b0;

        if (line_start) begin
            pix_next = '0;
            if (wall_top != '0) begin
                state_next = ST_CEIL;
            end else if (h_eff != '0) begin
                state_next = ST_WALL;
            end else begin
                state_next = ST_FLOOR;
            end
        end else if (pixel_en && state_reg != ST_IDLE) begin
            valid_next   = 1'b1;
            pix_next     = pix_inc;
            region_next  = state_region(state_reg);
            wall_en_next = (state_reg == ST_WALL);
            if (state_reg == ST_WALL) begin
                row_next = acc_row;
                acc_step = 1'b1;
            end
            // End of line takes precedence over any region boundary.
            if (pix_inc == VW) begin
                state_next = ST_IDLE;
                pix_next   = '0;
                done_next  = 1'b1;
            end else begin
                case (state_reg)
                    ST_CEIL: if (pix_inc == wall_top_reg)
                        state_next = has_wall_reg ? ST_WALL : ST_FLOOR;
                    ST_WALL: if (pix_inc == wall_end_reg)
                        state_next = ST_FLOOR;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            pix_reg      <= '0;
            wall_top_reg <= '0;
            wall_end_reg <= '0;
            has_wall_reg <= 1'b0;
            step_reg     <= '0;
            side_reg     <= 1'b0;
            wtid_reg     <= '0;
            col_reg      <= '0;
            row_reg      <= '0;
            wall_en_reg  <= 1'b0;
            region_reg   <= REGION_NONE;
            valid_reg    <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pix_reg     <= pix_next;
            row_reg     <= row_next;
            wall_en_reg <= wall_en_next;
            region_reg  <= region_next;
            valid_reg   <= valid_next;
            done_reg    <= done_next;
            if (line_start) begin
                wall_top_reg <= wall_top;
                wall_end_reg <= wall_end;
                has_wall_reg <= (h_eff != '0);
                step_reg     <= texv_step;
                side_reg     <= in_side;
                wtid_reg     <= in_wtid;
                col_reg      <= in_col;
            end
        end
    end

    texv_accum #(
        .STEP_FRAC (STEP_FRAC)
    ) u_texv_accum (
        .clk      (clk),
        .rst      (reset),
        .load     (line_start),
        .load_val (texv_init),
        .step_en  (acc_step),
        .step     (step_reg),
        .row      (acc_row)
    );

    assign tex_side  = side_reg;
    assign tex_wtid  = wtid_reg;
    assign tex_col   = col_reg;
    assign tex_row   = row_reg;
    assign wall_en   = wall_en_reg;
    assign region    = region_reg;
    assign out_valid = valid_reg;
    assign line_done = done_reg;

endmodule

// File: tb/tb_wall_texv_stepper.sv
// Directed bench for wall_texv_stepper: table of per-pixel expectations per line
// plus hand sequences for async reset and a mid-line restart.
module tb_wall_texv_stepper;

    localparam int VW = 640;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        line_start = 1'b0;
    logic        pixel_en = 1'b0;
    logic        in_side = 1'b0;
    logic [1:0]  in_wtid = '0;
    logic [5:0]  in_col = '0;
    logic [9:0]  wall_height = '0;
    logic [15:0] texv_step = '0;
    logic [15:0] texv_init = '0;
    logic        tex_side;
    logic [1:0]  tex_wtid;
    logic [5:0]  tex_col;
    logic [5:0]  tex_row;
    logic        wall_en;
    logic [1:0]  region;
    logic        out_valid;
    logic        line_done;

    int checks = 0;
    int passed = 0;

    typedef struct {
        int h; int wtid; int step; int init; int side; int col; int walls;
    } line_cfg_t;

    typedef struct {
        int line; int pix; int region; int row;   // row < 0: not checked
    } pix_vec_t;

    line_cfg_t cfg[5];
    pix_vec_t  vec[30];
    int        cap_region[VW];
    int        cap_row[VW];

    always #5 clk = ~clk;

    wall_texv_stepper dut (
        .clk         (clk),
        .reset       (reset),
        .line_start  (line_start),
        .pixel_en    (pixel_en),
        .in_side     (in_side),
        .in_wtid     (in_wtid),
        .in_col      (in_col),
        .wall_height (wall_height),
        .texv_step   (texv_step),
        .texv_init   (texv_init),
        .tex_side    (tex_side),
        .tex_wtid    (tex_wtid),
        .tex_col     (tex_col),
        .tex_row     (tex_row),
        .wall_en     (wall_en),
        .region      (region),
        .out_valid   (out_valid),
        .line_done   (line_done)
    );

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d, required %0d", name, actual, expected);
    endtask

    // Called at #1 after a posedge; leaves the bench at #1 after a posedge.
    task automatic start_line(input int li, input bit coincide);
        in_side     = cfg[li].side[0];
        in_wtid     = cfg[li].wtid[1:0];
        in_col      = cfg[li].col[5:0];
        wall_height = cfg[li].h[9:0];
        texv_step   = cfg[li].step[15:0];
        texv_init   = cfg[li].init[15:0];
        line_start  = 1'b1;
        pixel_en    = coincide;
        @(posedge clk); #1;
        line_start  = 1'b0;
        pixel_en    = 1'b0;
        check("start_no_valid", int'(out_valid), 0);
    endtask

    task automatic run_line(input int li, input bit coincide);
        int valid_cnt, done_cnt, done_at, wall_cnt, wall_mis;
        valid_cnt = 0; done_cnt = 0; done_at = -1; wall_cnt = 0; wall_mis = 0;
        start_line(li, coincide);
        check("latched_side", int'(tex_side), cfg[li].side);
        check("latched_wtid", int'(tex_wtid), cfg[li].wtid);
        check("latched_col", int'(tex_col), cfg[li].col);
        for (int i = 0; i < VW; i++) begin
            pixel_en = 1'b1;
            @(posedge clk); #1;
            cap_region[i] = int'(region);
            cap_row[i]    = int'(tex_row);
            valid_cnt += int'(out_valid);
            wall_cnt  += int'(wall_en);
            if (wall_en != (region == 2'd2)) wall_mis++;
            if (line_done) begin done_cnt++; done_at = i; end
        end
        pixel_en = 1'b0;
        @(posedge clk); #1;
        $display("line %0d: valid=%0d walls=%0d done=%0d@%0d", li, valid_cnt, wall_cnt, done_cnt, done_at);
        check("valid_count", valid_cnt, VW);
        check("done_count", done_cnt, 1);
        check("done_at_last", done_at, VW - 1);
        check("wall_count", wall_cnt, cfg[li].walls);
        check("wall_en_vs_region", wall_mis, 0);
        check("idle_no_valid", int'(out_valid), 0);
        check("idle_no_done", int'(line_done), 0);
        check("region_hold", int'(region), (cfg[li].walls == VW) ? 2 : 3);
        pixel_en = 1'b1;                      // ignored in IDLE
        @(posedge clk); #1;
        pixel_en = 1'b0;
        check("idle_pixel_ignored", int'(out_valid), 0);
        for (int v = 0; v < 30; v++) begin
            if (vec[v].line == li) begin
                check($sformatf("region_l%0d_p%0d", li, vec[v].pix), cap_region[vec[v].pix], vec[v].region);
                if (vec[v].row >= 0)
                    check($sformatf("row_l%0d_p%0d", li, vec[v].pix), cap_row[vec[v].pix], vec[v].row);
            end
        end
    endtask

    // Runs n pixels of line li and leaves pixel_en asserted.
    task automatic partial_line(input int li, input int n);
        int done_cnt;
        done_cnt = 0;
        start_line(li, 1'b0);
        for (int i = 0; i < n; i++) begin
            pixel_en = 1'b1;
            @(posedge clk); #1;
            if (line_done) done_cnt++;
        end
        $display("partial line %0d: %0d pixels, region=%0d row=%0d", li, n, region, tex_row);
        check("partial_no_done", done_cnt, 0);
    endtask

    initial begin
        cfg[0] = '{h: 64,   wtid: 1, step: 'h0400, init: 'h0000, side: 1, col: 5,  walls: 64};
        cfg[1] = '{h: 128,  wtid: 3, step: 'h0200, init: 'h0000, side: 0, col: 17, walls: 128};
        cfg[2] = '{h: 1000, wtid: 2, step: 'h0100, init: 'h1000, side: 1, col: 63, walls: 640};
        cfg[3] = '{h: 64,   wtid: 0, step: 'h0400, init: 'h0000, side: 0, col: 9,  walls: 0};
        cfg[4] = '{h: 3,    wtid: 2, step: 'h0400, init: 'hFC00, side: 1, col: 33, walls: 3};
        for (int v = 0; v < 30; v++) vec[v] = '{line: -1, pix: 0, region: 0, row: -1};
        vec[0]  = '{0, 0,   1, -1};
        vec[1]  = '{0, 287, 1, -1};
        vec[2]  = '{0, 288, 2, 0};
        vec[3]  = '{0, 289, 2, 1};
        vec[4]  = '{0, 351, 2, 63};
        vec[5]  = '{0, 352, 3, -1};
        vec[6]  = '{0, 639, 3, -1};
        vec[7]  = '{1, 255, 1, -1};
        vec[8]  = '{1, 256, 2, 0};
        vec[9]  = '{1, 257, 2, 0};
        vec[10] = '{1, 258, 2, 1};
        vec[11] = '{1, 383, 2, 63};
        vec[12] = '{1, 384, 3, -1};
        vec[13] = '{2, 0,   2, 4};
        vec[14] = '{2, 1,   2, 4};
        vec[15] = '{2, 4,   2, 5};
        vec[16] = '{2, 239, 2, 63};
        vec[17] = '{2, 240, 2, 0};
        vec[18] = '{2, 639, 2, 35};
        vec[19] = '{3, 0,   1, -1};
        vec[20] = '{3, 319, 1, -1};
        vec[21] = '{3, 320, 3, -1};
        vec[22] = '{3, 639, 3, -1};
        vec[23] = '{4, 317, 1, -1};
        vec[24] = '{4, 318, 2, 63};
        vec[25] = '{4, 319, 2, 0};
        vec[26] = '{4, 320, 2, 1};
        vec[27] = '{4, 321, 3, -1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(out_valid), 0);
        check("rst_region", int'(region), 0);
        check("rst_wtid", int'(tex_wtid), 0);
        check("rst_done", int'(line_done), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int li = 0; li < 5; li++) run_line(li, 1'b0);

        // Mid-line restart: line_start coincident with pixel_en of pixel 100.
        partial_line(0, 100);
        check("abort_pre_region", int'(region), 1);
        run_line(1, 1'b1);

        // Asynchronous reset in the middle of a wall span.
        partial_line(0, 300);
        check("pre_reset_wall_en", int'(wall_en), 1);
        check("pre_reset_row", int'(tex_row), 11);
        #2 reset = 1'b1;
        #1;
        $display("async reset: valid=%0d region=%0d wall_en=%0d row=%0d", out_valid, region, wall_en, tex_row);
        check("arst_valid", int'(out_valid), 0);
        check("arst_region", int'(region), 0);
        check("arst_wall_en", int'(wall_en), 0);
        check("arst_row", int'(tex_row), 0);
        check("arst_col", int'(tex_col), 0);
        check("arst_side", int'(tex_side), 0);
        reset = 1'b0;
        pixel_en = 1'b1;
        @(posedge clk); #1;
        pixel_en = 1'b0;
        check("post_reset_no_valid", int'(out_valid), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
